// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_pkg
// Description : Shared definitions for the handshake source arbiter: FSM
//               state encoding and the default data word width.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    // Default data word width; must match the Handshake_syn instance.
    localparam int unsigned DEF_WIDTH = 8;

    // Source-side transfer states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority selector. The search starts at
//               last_id+1 and wraps, so the most recent winner has the lowest
//               priority on the next pick.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_id,
    output logic [NREQ-1:0] winner,
    output logic [IDW-1:0]  winner_id,
    output logic            any
);

    logic [IDW-1:0] w_idx;

    // Walk the search order backwards so the nearest pending requester after
    // last_id is the one left standing.
    always_comb begin
        winner    = '0;
        winner_id = last_id;
        any       = 1'b0;
        w_idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(last_id) + k) % NREQ);
            if (req[w_idx]) begin
                winner        = '0;
                winner[w_idx] = 1'b1;
                winner_id     = w_idx;
                any           = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/handshake_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : handshake_src_arbiter
// Description : Shares one Handshake_syn instance between NREQ requesters.
//               One word is accepted by round-robin, launched with a single
//               sready pulse and held on din until the synchronizer reports
//               idle again; only then can the next word be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_src_arbiter
    import hs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       req_done,
    output logic                  sready,
    output logic [WIDTH-1:0]      din,
    input  logic                  sidle,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [CNTW-1:0]       xfer_cnt
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] w_win;
    logic [IDW-1:0]  w_win_id;
    logic            w_any;
    logic            w_accept;
    logic            w_complete;
    logic [NREQ-1:0] w_done_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req       (req_valid),
        .last_id   (grant_id),
        .winner    (w_win),
        .winner_id (w_win_id),
        .any       (w_any)
    );

    // A word is taken only from IDLE with the synchronizer idle; completion is
    // the synchronizer returning to idle after it has gone busy.
    assign w_accept   = (r_state == IDLE) && sidle && w_any;
    assign w_complete = (r_state == WAIT_HIGH) && sidle;
    assign req_ready  = ((r_state == IDLE) && sidle) ? w_win : '0;
    assign busy       = (r_state != IDLE);

    // Next-state logic for the single-transfer-in-flight sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!sidle)   w_state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (sidle)    w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Completion strobe goes back to whoever owns the finished transfer.
    always_comb begin
        w_done_nxt = '0;
        if (w_complete) begin
            w_done_nxt[grant_id] = 1'b1;
        end
    end

    // State, launch pulse, held word, owner id, completion pulse and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            sready   <= 1'b0;
            din      <= '0;
            grant_id <= IDW'(NREQ - 1);
            req_done <= '0;
            xfer_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            sready   <= w_accept;
            req_done <= w_done_nxt;
            if (w_accept) begin
                din      <= req_data[w_win_id*WIDTH +: WIDTH];
                grant_id <= w_win_id;
            end
            if (w_complete) begin
                xfer_cnt <= xfer_cnt + CNTW'(1);
            end
        end
    end

endmodule : handshake_src_arbiter
`default_nettype wire

// File: tb/tb_handshake_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_src_arbiter
// Description : Randomized self-checking bench. A transaction-level model of
//               requesters, the Handshake_syn idle behaviour and the arbiter
//               predicts every output; a second instance with a 4-bit counter
//               follows the same traffic to exercise counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_src_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int CNTW  = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  sidle;

    logic [NREQ-1:0]  req_ready,  req_ready4;
    logic [NREQ-1:0]  req_done,   req_done4;
    logic             sready,     sready4;
    logic [WIDTH-1:0] din,        din4;
    logic [IDW-1:0]   grant_id,   grant_id4;
    logic             busy,       busy4;
    logic [CNTW-1:0]  xfer_cnt;
    logic [3:0]       xfer_cnt4;

    always #5 clk = ~clk;

    handshake_src_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .sready(sready), .din(din),
        .sidle(sidle), .grant_id(grant_id), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    handshake_src_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready4), .req_done(req_done4), .sready(sready4), .din(din4),
        .sidle(sidle), .grant_id(grant_id4), .busy(busy4), .xfer_cnt(xfer_cnt4)
    );

    // Requester model
    bit         vld [NREQ];
    logic [7:0] dat [NREQ];

    // Transaction model of the arbiter and the synchronizer
    int         m_gid;
    logic [7:0] m_din;
    int         m_cnt;
    logic [3:0] m_done;
    bit         m_sready;
    bit         m_inflight;
    int         s_age;
    int         l_len;
    int         pick;
    bit         did_rst;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gid      = NREQ - 1;
        m_din      = '0;
        m_cnt      = 0;
        m_done     = '0;
        m_sready   = 1'b0;
        m_inflight = 1'b0;
        s_age      = 0;
        l_len      = 1;
    endtask

    task automatic check_regs();
        chk("sready",    sready,    m_sready);
        chk("din",       din,       m_din);
        chk("grant_id",  grant_id,  m_gid[IDW-1:0]);
        chk("busy",      busy,      m_inflight);
        chk("xfer_cnt",  xfer_cnt,  m_cnt[CNTW-1:0]);
        chk("req_done",  req_done,  m_done);
        chk("sready4",   sready4,   m_sready);
        chk("din4",      din4,      m_din);
        chk("grant_id4", grant_id4, m_gid[IDW-1:0]);
        chk("busy4",     busy4,     m_inflight);
        chk("xfer_cnt4", xfer_cnt4, m_cnt[3:0]);
        chk("req_done4", req_done4, m_done);
    endtask

    // Round-robin rule: first valid requester after the last grant, wrapping.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (vld[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_inputs(input int cyc);
        if (cyc >= 40) begin
            for (int i = 0; i < NREQ; i++) begin
                if (vld[i]) begin
                    if ($urandom % 32 == 0) vld[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = vld[i];
            req_data[i*WIDTH +: WIDTH] = dat[i];
        end
        if (m_inflight) sidle = !(s_age >= 2 && s_age < 2 + l_len);
        else            sidle = ($urandom % 8 != 0);
    endtask

    initial begin
        logic [3:0] exp_rdy;
        n_checks = 0;
        n_errors = 0;
        did_rst  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        sidle     = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_regs();
        chk("req_ready_rst", req_ready, 4'b0000);

        // All four pending from reset with a known data pattern.
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b1;
            dat[i] = 8'h10 + 8'(i * 8'h11);
        end
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (!did_rst && cyc > 1500 && m_inflight && s_age >= 3) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_regs();
                @(posedge clk);
                #1;
                check_regs();
                sidle   = 1'b1;
                rst_n   = 1'b1;
                did_rst = 1'b1;
            end
            check_regs();
            drive_inputs(cyc);
            #1;

            pick    = rr_pick(m_gid);
            exp_rdy = '0;
            if (!m_inflight && sidle && pick >= 0) exp_rdy[pick] = 1'b1;
            chk("req_ready",  req_ready,  exp_rdy);
            chk("req_ready4", req_ready4, exp_rdy);

            m_done   = '0;
            m_sready = 1'b0;
            if (m_inflight) begin
                if (s_age == 2 + l_len) begin
                    m_done[m_gid] = 1'b1;
                    m_cnt++;
                    m_inflight = 1'b0;
                end else begin
                    s_age++;
                end
            end else if (sidle && pick >= 0) begin
                m_din      = dat[pick];
                m_gid      = pick;
                m_sready   = 1'b1;
                m_inflight = 1'b1;
                s_age      = 1;
                l_len      = ($urandom % 10 == 0) ? 50 : int'($urandom_range(1, 4));
                vld[pick]  = 1'b0;
            end
        end

        chk("reset_exercised", did_rst, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_handshake_src_arbiter
`default_nettype wire
